// File: rtl/l1_dm_pkg.sv
// Shared types and width helpers for the direct-mapped L1 data array.
package l1_dm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        EVICT_RD  = 2'd2,
        EVICT_OUT = 2'd3
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned set_width(input int unsigned sets);
        return clog2_min1(sets);
    endfunction

    function automatic int unsigned word_width(input int unsigned line_words);
        return clog2_min1(line_words);
    endfunction

    function automatic int unsigned way_width(input int unsigned ways);
        return clog2_min1(ways);
    endfunction

endpackage

// File: rtl/sram_sp_be.sv
// Single-port synchronous SRAM with byte write enables; read data only changes on a read.
module sram_sp_be #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_en,
    input  logic               i_we,
    input  logic [WIDTH/8-1:0] i_be,
    input  logic [AW-1:0]      i_addr,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < WIDTH / 8; b++) begin
                    if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/l1_dm_array.sv
// L1 data array: core word access, line fill and line evict sharing one SRAM per way.
module l1_dm_array
    import l1_dm_pkg::*;
#(
    parameter  int unsigned WIDTH      = 32,
    parameter  int unsigned SETS       = 256,
    parameter  int unsigned LINE_WORDS = 4,
    parameter  int unsigned WAYS       = 2,
    localparam int unsigned SW         = set_width(SETS),
    localparam int unsigned OW         = word_width(LINE_WORDS),
    localparam int unsigned AW         = SW + OW,
    localparam int unsigned WW         = way_width(WAYS),
    localparam int unsigned BW         = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             core_req_val,
    output logic             core_req_rdy,
    input  logic [AW-1:0]    core_req_addr,
    input  logic [WW-1:0]    core_req_way,
    input  logic             core_req_we,
    input  logic [BW-1:0]    core_req_be,
    input  logic [WIDTH-1:0] core_req_wdata,
    output logic             core_resp_val,
    output logic [WIDTH-1:0] core_resp_rdata,
    input  logic             fill_req_val,
    output logic             fill_req_rdy,
    input  logic [SW-1:0]    fill_req_set,
    input  logic [WW-1:0]    fill_req_way,
    input  logic             fill_data_val,
    output logic             fill_data_rdy,
    input  logic [WIDTH-1:0] fill_data,
    output logic             fill_done,
    input  logic             evict_req_val,
    output logic             evict_req_rdy,
    input  logic [SW-1:0]    evict_req_set,
    input  logic [WW-1:0]    evict_req_way,
    output logic             evict_data_val,
    input  logic             evict_data_rdy,
    output logic [WIDTH-1:0] evict_data,
    output logic             evict_last
);

    state_e           r_state, w_state_d;
    logic [OW-1:0]    r_cnt, w_cnt_d;
    logic [SW-1:0]    r_set, w_set_d;
    logic [WW-1:0]    r_way, w_way_d, r_rd_way;
    logic             r_resp_val, w_resp_val_d;
    logic             r_fill_done, w_fill_done_d;
    logic [WIDTH-1:0] r_rdata_hold;
    logic             w_last;

    logic             w_en, w_we;
    logic [BW-1:0]    w_be;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_wdata;
    logic [WW-1:0]    w_way;
    logic [WIDTH-1:0] w_rdata [WAYS];
    logic [WIDTH-1:0] w_rd_mux;

    assign w_last = (r_cnt == OW'(LINE_WORDS - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_set        <= '0;
            r_way        <= '0;
            r_rd_way     <= '0;
            r_resp_val   <= 1'b0;
            r_fill_done  <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_set       <= w_set_d;
            r_way       <= w_way_d;
            r_resp_val  <= w_resp_val_d;
            r_fill_done <= w_fill_done_d;
            if (w_en && !w_we) r_rd_way <= (WAYS == 1) ? '0 : w_way;
            // Keep the last response visible once the SRAM output moves on.
            if (r_resp_val) r_rdata_hold <= w_rd_mux;
        end
    end

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_set_d        = r_set;
        w_way_d        = r_way;
        w_resp_val_d   = 1'b0;
        w_fill_done_d  = 1'b0;
        w_en           = 1'b0;
        w_we           = 1'b0;
        w_be           = '0;
        w_addr         = {r_set, r_cnt};
        w_wdata        = fill_data;
        w_way          = r_way;
        core_req_rdy   = 1'b0;
        fill_req_rdy   = 1'b0;
        evict_req_rdy  = 1'b0;
        fill_data_rdy  = 1'b0;
        evict_data_val = 1'b0;
        evict_last     = 1'b0;
        unique case (r_state)
            IDLE: begin
                evict_req_rdy = 1'b1;
                fill_req_rdy  = !evict_req_val;
                core_req_rdy  = !evict_req_val && !fill_req_val;
                if (evict_req_val) begin
                    w_state_d = EVICT_RD;
                    w_cnt_d   = '0;
                    w_set_d   = evict_req_set;
                    w_way_d   = evict_req_way;
                end else if (fill_req_val) begin
                    w_state_d = FILL;
                    w_cnt_d   = '0;
                    w_set_d   = fill_req_set;
                    w_way_d   = fill_req_way;
                end else if (core_req_val) begin
                    w_en         = 1'b1;
                    w_we         = core_req_we;
                    w_be         = core_req_be;
                    w_addr       = core_req_addr;
                    w_wdata      = core_req_wdata;
                    w_way        = core_req_way;
                    w_resp_val_d = !core_req_we;
                end
            end
            FILL: begin
                fill_data_rdy = 1'b1;
                if (fill_data_val) begin
                    w_en    = 1'b1;
                    w_we    = 1'b1;
                    w_be    = '1;
                    w_cnt_d = r_cnt + OW'(1);
                    if (w_last) begin
                        w_state_d     = IDLE;
                        w_fill_done_d = 1'b1;
                    end
                end
            end
            EVICT_RD: begin
                w_en      = 1'b1;
                w_state_d = EVICT_OUT;
            end
            EVICT_OUT: begin
                evict_data_val = 1'b1;
                evict_last     = w_last;
                if (evict_data_rdy) begin
                    w_cnt_d   = r_cnt + OW'(1);
                    w_state_d = w_last ? IDLE : EVICT_RD;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic w_sel;
        assign w_sel = (WAYS == 1) || (w_way == WW'(g));
        sram_sp_be #(
            .WIDTH (WIDTH),
            .DEPTH (SETS * LINE_WORDS)
        ) u_sram (
            .i_clk   (CLK),
            .i_en    (w_en && w_sel),
            .i_we    (w_we),
            .i_be    (w_be),
            .i_addr  (w_addr),
            .i_wdata (w_wdata),
            .o_rdata (w_rdata[g])
        );
    end

    assign w_rd_mux        = (WAYS == 1) ? w_rdata[0] : w_rdata[r_rd_way];
    assign core_resp_val   = r_resp_val;
    assign core_resp_rdata = r_resp_val ? w_rd_mux : r_rdata_hold;
    assign fill_done       = r_fill_done;
    // SRAM is idle in EVICT_OUT, so its output register holds the beat stable.
    assign evict_data      = (r_state == EVICT_OUT) ? w_rd_mux : '0;

endmodule

// File: tb/tb_l1_dm_array.sv
// Directed bench for l1_dm_array: core table, fill/evict bursts, priority and mid-burst reset.
module tb_l1_dm_array;

    localparam int AW = 10;
    localparam int SW = 8;
    localparam int BW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          core_req_val, core_req_rdy, core_req_we, core_resp_val;
    logic [AW-1:0] core_req_addr;
    logic [0:0]    core_req_way;
    logic [BW-1:0] core_req_be;
    logic [31:0]   core_req_wdata, core_resp_rdata;
    logic          fill_req_val, fill_req_rdy, fill_data_val, fill_data_rdy, fill_done;
    logic [SW-1:0] fill_req_set;
    logic [0:0]    fill_req_way;
    logic [31:0]   fill_data;
    logic          evict_req_val, evict_req_rdy, evict_data_val, evict_data_rdy, evict_last;
    logic [SW-1:0] evict_req_set;
    logic [0:0]    evict_req_way;
    logic [31:0]   evict_data;

    l1_dm_array dut (
        .CLK             (CLK),
        .RST             (RST),
        .core_req_val    (core_req_val),
        .core_req_rdy    (core_req_rdy),
        .core_req_addr   (core_req_addr),
        .core_req_way    (core_req_way),
        .core_req_we     (core_req_we),
        .core_req_be     (core_req_be),
        .core_req_wdata  (core_req_wdata),
        .core_resp_val   (core_resp_val),
        .core_resp_rdata (core_resp_rdata),
        .fill_req_val    (fill_req_val),
        .fill_req_rdy    (fill_req_rdy),
        .fill_req_set    (fill_req_set),
        .fill_req_way    (fill_req_way),
        .fill_data_val   (fill_data_val),
        .fill_data_rdy   (fill_data_rdy),
        .fill_data       (fill_data),
        .fill_done       (fill_done),
        .evict_req_val   (evict_req_val),
        .evict_req_rdy   (evict_req_rdy),
        .evict_req_set   (evict_req_set),
        .evict_req_way   (evict_req_way),
        .evict_data_val  (evict_data_val),
        .evict_data_rdy  (evict_data_rdy),
        .evict_data      (evict_data),
        .evict_last      (evict_last)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic          way;
        logic [BW-1:0] be;
        logic [31:0]   wdata;
        logic          exp_val;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs [13];
    int   n_checks = 0;
    int   n_errors = 0;
    int   beat, stall, fcnt, ecnt, ord_code, waits;
    logic he, hf, hc, fb, eb;
    logic sched [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic core_rd(input string name, input logic [AW-1:0] addr, input logic way,
                           input logic [31:0] exp);
        int w;
        core_req_val  = 1'b1;
        core_req_we   = 1'b0;
        core_req_addr = addr;
        core_req_way  = way;
        core_req_be   = '1;
        @(negedge CLK);
        w = 0;
        while (!core_req_rdy && w < 20) begin
            @(negedge CLK);
            w++;
        end
        check($sformatf("%s rdy", name), core_req_rdy, 1);
        @(posedge CLK); #1;
        core_req_val = 1'b0;
        check($sformatf("%s resp_val", name), core_resp_val, 1);
        check($sformatf("%s rdata", name), core_resp_rdata, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s core_resp_val", tag), core_resp_val, 0);
        check($sformatf("%s core_resp_rdata", tag), core_resp_rdata, 0);
        check($sformatf("%s fill_done", tag), fill_done, 0);
        check($sformatf("%s fill_data_rdy", tag), fill_data_rdy, 0);
        check($sformatf("%s evict_data_val", tag), evict_data_val, 0);
        check($sformatf("%s evict_last", tag), evict_last, 0);
        check($sformatf("%s evict_data", tag), evict_data, 0);
        check($sformatf("%s evict_req_rdy", tag), evict_req_rdy, 1);
        check($sformatf("%s core_req_rdy", tag), core_req_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        core_req_val = 0; core_req_we = 0; core_req_addr = '0; core_req_way = '0;
        core_req_be = '0; core_req_wdata = '0;
        fill_req_val = 0; fill_req_set = '0; fill_req_way = '0; fill_data_val = 0; fill_data = '0;
        evict_req_val = 0; evict_req_set = '0; evict_req_way = '0; evict_data_rdy = 0;

        //            we    addr      way   be       wdata         val   rdata
        vecs[0]  = '{1'b1, 10'd5,    1'b1, 4'b1111, 32'h11223344, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 10'd5,    1'b0, 4'b1111, 32'h55667788, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 10'd5,    1'b1, 4'b0011, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 10'd5,    1'b1, 4'b0000, 32'h0,        1'b1, 32'h1122CCDD};
        vecs[4]  = '{1'b0, 10'd5,    1'b0, 4'b0000, 32'h0,        1'b1, 32'h55667788};
        vecs[5]  = '{1'b1, 10'd0,    1'b0, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h55667788};
        vecs[6]  = '{1'b1, 10'd1,    1'b0, 4'b1111, 32'h01020304, 1'b0, 32'h55667788};
        vecs[7]  = '{1'b1, 10'd0,    1'b0, 4'b1000, 32'h77000000, 1'b0, 32'h55667788};
        vecs[8]  = '{1'b0, 10'd0,    1'b0, 4'b0000, 32'h0,        1'b1, 32'h77ADBEEF};
        vecs[9]  = '{1'b0, 10'd1,    1'b0, 4'b0000, 32'h0,        1'b1, 32'h01020304};
        vecs[10] = '{1'b1, 10'd1023, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h01020304};
        vecs[11] = '{1'b0, 10'd1023, 1'b1, 4'b0000, 32'h0,        1'b1, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 10'd5,    1'b1, 4'b0000, 32'h0,        1'b1, 32'h1122CCDD};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        check("reset fill_req_rdy", fill_req_rdy, 1);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Core table, one request per cycle
        for (int i = 0; i < 13; i++) begin
            core_req_val   = 1'b1;
            core_req_we    = vecs[i].we;
            core_req_addr  = vecs[i].addr;
            core_req_way   = vecs[i].way;
            core_req_be    = vecs[i].be;
            core_req_wdata = vecs[i].wdata;
            @(posedge CLK); #1;
            check($sformatf("vec%0d resp_val", i), core_resp_val, vecs[i].exp_val);
            check($sformatf("vec%0d rdata", i), core_resp_rdata, vecs[i].exp_rdata);
        end
        core_req_val = 1'b0;

        // Fill set 3 way 0 with a gap cycle
        fill_req_val = 1'b1; fill_req_set = 8'd3; fill_req_way = 1'b0;
        core_req_val = 1'b1; core_req_we = 1'b0; core_req_addr = 10'd0;
        @(negedge CLK);
        check("fill accept rdy", fill_req_rdy, 1);
        check("core blocked by fill", core_req_rdy, 0);
        @(posedge CLK); #1;
        fill_req_val = 1'b0; core_req_val = 1'b0;
        check("fill state data_rdy", fill_data_rdy, 1);
        check("fill state evict_rdy", evict_req_rdy, 0);
        sched[0] = 1; sched[1] = 1; sched[2] = 0; sched[3] = 1; sched[4] = 1;
        beat = 0;
        for (int k = 0; k < 5; k++) begin
            fill_data_val = sched[k];
            fill_data     = 32'hA0 + beat;
            @(posedge CLK); #1;
            if (sched[k]) beat++;
            check($sformatf("fill step%0d done", k), fill_done, (k == 4));
        end
        fill_data_val = 1'b0;
        check("fill end data_rdy", fill_data_rdy, 0);
        @(posedge CLK); #1;
        check("fill done single pulse", fill_done, 0);
        for (int w = 0; w < 4; w++) core_rd($sformatf("fill word%0d", 12 + w), AW'(12 + w), 1'b0,
                                            32'hA0 + w);

        // Evict set 3 way 0, sink stalls 3 cycles on beat 1
        evict_req_val = 1'b1; evict_req_set = 8'd3; evict_req_way = 1'b0; evict_data_rdy = 1'b0;
        @(posedge CLK); #1;
        evict_req_val = 1'b0;
        beat = 0; stall = 0;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            if (evict_data_val) begin
                check($sformatf("evict beat%0d data", beat), evict_data, 32'hA0 + beat);
                check($sformatf("evict beat%0d last", beat), evict_last, (beat == 3));
                if (beat == 1 && stall < 3) begin
                    evict_data_rdy = 1'b0;
                    stall++;
                end else begin
                    evict_data_rdy = 1'b1;
                    beat++;
                end
            end else begin
                evict_data_rdy = 1'b0;
            end
            @(posedge CLK); #1;
        end
        evict_data_rdy = 1'b0;
        check("evict beat count", beat, 4);
        check("evict stall cycles", stall, 3);
        check("evict end val", evict_data_val, 0);
        check("evict end idle", evict_req_rdy, 1);

        // Evict, fill and core requested together
        core_req_val = 1'b1; core_req_we = 1'b0; core_req_addr = 10'd12; core_req_way = 1'b0;
        fill_req_val = 1'b1; fill_req_set = 8'd4; fill_req_way = 1'b1;
        evict_req_val = 1'b1; evict_req_set = 8'd3; evict_req_way = 1'b0;
        evict_data_rdy = 1'b1; fill_data_val = 1'b1; fill_data = 32'hB0;
        fcnt = 0; ecnt = 0; ord_code = 0;
        @(negedge CLK);
        check("prio evict_rdy", evict_req_rdy, 1);
        check("prio fill_rdy", fill_req_rdy, 0);
        check("prio core_rdy", core_req_rdy, 0);
        for (int c = 0; c < 60 && ord_code < 100; c++) begin
            if (c != 0) @(negedge CLK);
            he = evict_req_val && evict_req_rdy;
            hf = fill_req_val && fill_req_rdy;
            hc = core_req_val && core_req_rdy;
            fb = fill_data_val && fill_data_rdy;
            eb = evict_data_val && evict_data_rdy;
            if (int'(he) + int'(hf) + int'(hc) > 1)
                check("prio single accept", int'(he) + int'(hf) + int'(hc), 1);
            if (eb) check($sformatf("prio evict beat%0d", ecnt), evict_data, 32'hA0 + ecnt);
            @(posedge CLK); #1;
            if (he) begin evict_req_val = 1'b0; ord_code = ord_code * 10 + 1; end
            if (hf) begin fill_req_val = 1'b0; ord_code = ord_code * 10 + 2; end
            if (hc) begin
                core_req_val = 1'b0;
                ord_code = ord_code * 10 + 3;
                check("prio core resp_val", core_resp_val, 1);
                check("prio core rdata", core_resp_rdata, 32'hA0);
            end
            if (fb) begin fcnt++; fill_data = 32'hB0 + fcnt; end
            if (eb) ecnt++;
        end
        fill_data_val = 1'b0; evict_data_rdy = 1'b0;
        check("prio order", ord_code, 123);
        check("prio fill beats", fcnt, 4);
        check("prio evict beats", ecnt, 4);
        core_rd("prio fill word16", 10'd16, 1'b1, 32'hB0);
        core_rd("prio fill word19", 10'd19, 1'b1, 32'hB3);

        // Reset after two fill beats
        fill_req_val = 1'b1; fill_req_set = 8'd3; fill_req_way = 1'b1;
        @(posedge CLK); #1;
        fill_req_val = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fill_data_val = 1'b1;
            fill_data     = 32'hC0 + k;
            @(posedge CLK); #1;
        end
        fill_data_val = 1'b0;
        RST = 1'b1;
        #1;
        check_reset_outputs("midfill rst");
        @(negedge CLK);
        RST = 1'b0;
        fill_req_val = 1'b1; fill_req_set = 8'd5; fill_req_way = 1'b0;
        #1;
        check("refill rdy", fill_req_rdy, 1);
        @(posedge CLK); #1;
        fill_req_val = 1'b0;
        check("refill accepted", fill_data_rdy, 1);
        for (int k = 0; k < 4; k++) begin
            fill_data_val = 1'b1;
            fill_data     = 32'hD0 + k;
            @(posedge CLK); #1;
        end
        fill_data_val = 1'b0;
        check("refill done", fill_done, 1);
        core_rd("partial word12", 10'd12, 1'b1, 32'hC0);
        core_rd("partial word13", 10'd13, 1'b1, 32'hC1);
        core_rd("refill word20", 10'd20, 1'b0, 32'hD0);
        core_rd("refill word23", 10'd23, 1'b0, 32'hD3);
        core_rd("kept word12 way0", 10'd12, 1'b0, 32'hA0);

        waits = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
